// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one single-beat register bus among NUM_REQ requesters.
// Latency: grant sampled in IDLE -> strobe next cycle -> rsp_valid three cycles after the request.
// Backpressure: requesters hold their request until req_ready; one access per 3 cycles, no queueing.
//
// Ports:
//   clk, reset              : single clock, synchronous active-high reset
//   req_valid/req_write     : per-requester request and direction (1 = write)
//   req_addr/req_wdata      : flattened per-requester address / write data
//   req_ready/rsp_valid     : one-hot accept pulse / one-hot completion pulse
//   rsp_rdata               : read data for the completing requester
//   io_addr/io_wdata        : bus address / write data, held outside ISSUE
//   io_write/io_read        : one-cycle bus strobes
//   io_rdata                : bus read data, valid the cycle after io_read
module io_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         io_addr,
  output logic                      io_write,
  output logic                      io_read,
  output logic [DATA_W-1:0]         io_wdata,
  input  logic [DATA_W-1:0]         io_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic             pick_vld;
  logic             wr_flag;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes and accept are decoded from state so a reset-abort clears them
  // in the very next cycle.
  always_comb begin
    state_nxt = state;
    io_write  = 1'b0;
    io_read   = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        io_write       = wr_flag;
        io_read        = !wr_flag;
        req_ready[gnt] = 1'b1;
        state_nxt      = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_addr    <= '0;
      io_wdata   <= '0;
      wr_flag    <= 1'b0;
      gnt        <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= '0;
      if (state == IDLE && pick_vld) begin
        gnt        <= pick;
        last_grant <= pick;
        wr_flag    <= req_write[pick];
        io_addr    <= req_addr[pick*ADDR_W +: ADDR_W];
        io_wdata   <= req_wdata[pick*DATA_W +: DATA_W];
      end
      // Bus read data arrives during RESP; the completion pulse lands in the
      // following cycle, overlapping the next arbitration.
      if (state == RESP) begin
        rsp_valid[gnt] <= 1'b1;
        if (!wr_flag) rsp_rdata <= io_rdata;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   io_addr;
  logic            io_write;
  logic            io_read;
  logic [DW-1:0]   io_wdata;
  logic [DW-1:0]   io_rdata;

  io_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .io_addr   (io_addr),
    .io_write  (io_write),
    .io_read   (io_read),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int both_hi  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus-side register file: 16 words, read data returned one cycle after io_read.
  logic [31:0] mem    [16];
  logic [31:0] shadow [16];

  always @(posedge clk) begin
    if (io_write) mem[io_addr[5:2]] = io_wdata;
    if (io_read)  io_rdata <= mem[io_addr[5:2]];
  end

  // Logs: grants (requester, cycle), expected responses, observed responses.
  int          gl[$];
  int          tl[$];
  int          eq_idx[$];
  logic [31:0] eq_dat[$];
  int          rq_idx[$];
  logic [31:0] rq_dat[$];
  logic [31:0] exp_last;
  int          mg;
  logic [31:0] ma;

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (io_read && io_write) both_hi++;
    if (|req_ready) begin
      mg = oh2idx(req_ready);
      gl.push_back(mg);
      tl.push_back(cyc);
      ma = req_addr[mg*AW +: AW];
      if (req_write[mg]) shadow[ma[5:2]] = req_wdata[mg*DW +: DW];
      else               exp_last = shadow[ma[5:2]];
      eq_idx.push_back(mg);
      eq_dat.push_back(exp_last);
    end
    if (|rsp_valid) begin
      rq_idx.push_back(oh2idx(rsp_valid));
      rq_dat.push_back(rsp_rdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    gl.delete(); tl.delete();
    eq_idx.delete(); eq_dat.delete();
    rq_idx.delete(); rq_dat.delete();
    exp_last = '0;
    reset = 1'b0;
  endtask

  // Wait for n grants; with drop set each requester releases valid on its accept,
  // otherwise all valids are released once the n-th grant is seen.
  task automatic serve(input int n, input bit drop, input string tag);
    int budget = 300;
    while (gl.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (drop) req_valid = req_valid & ~req_ready;
    end
    if (!drop) req_valid = '0;
    check({tag, "_grants"}, 64'(gl.size()), 64'(n));
    tick();
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    while (rq_idx.size() > 0 && eq_idx.size() > 0) begin
      check({tag, "_rsp_idx"}, 64'(rq_idx.pop_front()), 64'(eq_idx.pop_front()));
      check({tag, "_rsp_dat"}, 64'(rq_dat.pop_front()), 64'(eq_dat.pop_front()));
    end
    check({tag, "_unmatched"}, 64'(rq_idx.size() + eq_idx.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mask;
    int cnt;
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'h1000 + 32'(i) * 32'h11;
      shadow[i] = mem[i];
    end
    mem[2]    = 32'hA5;
    shadow[2] = 32'hA5;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    exp_last  = '0;

    // Reset values
    do_reset(3);
    check("rst_io_addr",   64'(io_addr),   64'd0);
    check("rst_io_wdata",  64'(io_wdata),  64'd0);
    check("rst_io_write",  64'(io_write),  64'd0);
    check("rst_io_read",   64'(io_read),   64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);

    // Single read by requester 2 at 0x08
    set_req(2, 1'b0, 32'h08, 32'h0);
    req_valid = 4'b0100;
    tick();
    check("rd_io_read",   64'(io_read),   64'd1);
    check("rd_io_write",  64'(io_write),  64'd0);
    check("rd_io_addr",   64'(io_addr),   64'h08);
    check("rd_req_ready", 64'(req_ready), 64'b0100);
    req_valid = '0;
    tick();
    check("rd_strobe_off", 64'(io_read),  64'd0);
    check("rd_io_rdata",   64'(io_rdata), 64'hA5);
    tick();
    check("rd_rsp_valid", 64'(rsp_valid), 64'b0100);
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'hA5);
    tick();
    check("rd_rsp_pulse", 64'(rsp_valid), 64'd0);

    // Single write by requester 1: 0x3C to 0x04
    set_req(1, 1'b1, 32'h04, 32'h3C);
    req_valid = 4'b0010;
    tick();
    check("wr_io_write",  64'(io_write),  64'd1);
    check("wr_io_read",   64'(io_read),   64'd0);
    check("wr_io_wdata",  64'(io_wdata),  64'h3C);
    check("wr_io_addr",   64'(io_addr),   64'h04);
    check("wr_req_ready", 64'(req_ready), 64'b0010);
    req_valid = '0;
    tick();
    check("wr_strobe_off", 64'(io_write), 64'd0);
    tick();
    check("wr_rsp_valid", 64'(rsp_valid), 64'b0010);
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'hA5);
    check("wr_mem",       64'(mem[1]),    64'h3C);
    drain("single");

    // Fairness: all four valid through reset, 12 grants
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'(i * 4), 32'h0);
    req_valid = 4'b1111;
    do_reset(2);
    check("rst_wins_ready", 64'(req_ready), 64'd0);
    check("rst_wins_read",  64'(io_read),   64'd0);
    serve(12, 1'b0, "rr");
    for (int k = 0; k < gl.size(); k++)
      check($sformatf("rr_order[%0d]", k), 64'(gl[k]), 64'(k % N));
    for (int k = 1; k < tl.size(); k++)
      check($sformatf("rr_spacing[%0d]", k), 64'(tl[k] - tl[k-1]), 64'd3);
    drain("rr");

    // Req 3 and req 0 both valid after last_grant = 3
    gl.delete(); tl.delete();
    set_req(0, 1'b0, 32'h00, 32'h0);
    set_req(3, 1'b0, 32'h0C, 32'h0);
    req_valid = 4'b1001;
    serve(2, 1'b1, "wrap");
    check("wrap_first",  64'(gl[0]), 64'd0);
    check("wrap_second", 64'(gl[1]), 64'd3);
    drain("wrap");

    // Reset during RESP of a read by requester 1
    gl.delete(); tl.delete();
    set_req(1, 1'b0, 32'h0C, 32'h0);
    req_valid = 4'b0010;
    tick();
    check("abort_issue", 64'(io_read), 64'd1);
    req_valid = '0;
    tick();
    do_reset(1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_ready",     64'(req_ready), 64'd0);
    check("abort_strobe",    64'(io_read),   64'd0);
    tick();
    check("abort_rsp_late", 64'(rsp_valid), 64'd0);
    set_req(0, 1'b0, 32'h00, 32'h0);
    set_req(2, 1'b0, 32'h08, 32'h0);
    req_valid = 4'b0101;
    serve(2, 1'b1, "post_rst");
    check("post_rst_first",  64'(gl[0]), 64'd0);
    check("post_rst_second", 64'(gl[1]), 64'd2);
    drain("post_rst");

    // Random mix of reads and writes across requesters
    for (int r = 0; r < 12; r++) begin
      gl.delete(); tl.delete();
      mask = $urandom_range(1, 15);
      cnt  = 0;
      for (int i = 0; i < N; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom);
        if (mask[i]) cnt++;
      end
      req_valid = 4'(mask);
      serve(cnt, 1'b1, $sformatf("rnd%0d", r));
      drain($sformatf("rnd%0d", r));
    end

    check("both_strobes", 64'(both_hi), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Round-robin arbiter that shares the single memory-mapped register bus of the IO handler (io_addr/io_write/io_read/io_wdata/io_rdata) among NUM_REQ requesters, e.g. CPU, DMA and a status-polling engine. Each granted request becomes exactly one single-beat bus access. Read data and a completion pulse are returned to the originating requester only. Sits between the requester fabric and the IO handler's register port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  DATA_W  read data, shared by all requesters, qualified by rsp_valid
- io_addr  out  ADDR_W  bus address
- io_write  out  1  write strobe, one cycle per write
- io_read  out  1  read strobe, one cycle per read
- io_wdata  out  DATA_W  bus write data
- io_rdata  in  DATA_W  read data, valid in the cycle after io_read

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: if any req_valid is set, grant one requester g, latch req_write[g], addr[g] and wdata[g] into io_* registers, record g, set last_grant=g, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - io_write=latched write flag, io_read=!latched write flag.
  - req_ready[g]=1; this is the handshake completion.
  - Always go to RESP.
- RESP:
  - Strobes are 0.
  - On a read, capture io_rdata into rsp_rdata at the end of the cycle. On a write, rsp_rdata holds its previous value.
  - Always go to IDLE.
- rsp_valid[g] is a registered one-cycle pulse, asserted in the cycle after RESP. That cycle is the next IDLE, so arbitration may overlap it.
- Round robin: search order is last_grant+1, last_grant+2, … modulo NUM_REQ; the first set req_valid wins. last_grant resets to NUM_REQ-1, so requester 0 has top priority after reset.
- Requesters must hold req_valid, req_write, req_addr and req_wdata stable from assertion until they see req_ready. Changes before req_ready are not tracked, because fields are latched on IDLE→ISSUE. req_valid may deassert in the cycle after req_ready.
- A requester that keeps req_valid high after its req_ready issues a new request, re-arbitrated fairly in the next IDLE.
- Dropping req_valid while in IDLE before being granted is legal; nothing is issued for it.
- io_addr and io_wdata hold their last values outside ISSUE.
- At most one of io_write/io_read is high; never both. Strobes only in ISSUE.

## Timing
- Reset values: io_addr=0, io_wdata=0, io_write=0, io_read=0, req_ready=0, rsp_valid=0, rsp_rdata=0, state=IDLE, last_grant=NUM_REQ-1.
- Request sampled in IDLE at cycle N:
  - N+1: ISSUE, strobe and req_ready.
  - N+2: RESP, io_rdata sampled.
  - N+3: rsp_valid, rsp_rdata valid.
- Back-to-back requests: one access every 3 cycles. Bus utilisation is at most 1/3.
- Fairness: with all requesters continuously valid, each is granted exactly once in every NUM_REQ consecutive grants.
- Reset asserted in ISSUE or RESP aborts the access:
  - strobes and req_ready are 0 from the next cycle.
  - no rsp_valid is produced for the aborted access.
  - last_grant returns to NUM_REQ-1.
- Reset asserted in the same cycle as req_valid: reset wins; no grant.

## Test plan
- Single read: after reset, req 2 reads addr 0x08. Required response:
  - io_read high for exactly 1 cycle, with io_addr=0x08, one cycle after req_valid.
  - io_rdata=0xA5 in the next cycle.
  - rsp_valid=4'b0100 and rsp_rdata=0xA5, 3 cycles after the request.
- Single write: req 1 writes 0x3C to addr 0x04. Required response:
  - io_write high 1 cycle with io_wdata=0x3C; io_read stays 0.
  - req_ready=4'b0010, then rsp_valid=4'b0010.
  - rsp_rdata unchanged.
- All four requesters held valid from reset for 12 grants → grant order 0,1,2,3,0,1,2,3,0,1,2,3; every ISSUE is exactly 3 cycles after the previous one.
- Req 3 and req 0 both valid with last_grant=3 → req 0 is granted first, then req 3.
- Reset pulsed during the RESP of a read by req 1 → no rsp_valid appears; the next request from req 2 completes normally; req 0 is again highest priority.
- Random mix of reads/writes across all requesters with a register model on the bus side → every rsp_rdata matches the model, and no cycle has io_read and io_write both high.
